// File: rtl/prio_enc_arb_pkg.sv
// Shared encodings for the prio_enc_arb request arbiter.
package prio_enc_pkg;
  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;
  localparam int   STAT_W     = 16;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;
endpackage

// File: rtl/prio_enc_arb_if.sv
// Request/selection bundle between the request sources, the arbiter and the consumer.
interface prio_enc_arb_if #(parameter int N = 4);
  localparam int W = $clog2(N);

  logic [N-1:0] req;
  logic         mode;
  logic [N-1:0] req_ack;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_idx;
  logic [N-1:0] out_onehot;

  modport master (
    input  req, mode, out_ready,
    output req_ack, out_valid, out_idx, out_onehot
  );

  modport slave (
    output req, mode, out_ready,
    input  req_ack, out_valid, out_idx, out_onehot
  );
endinterface

// File: rtl/prio_enc_arb_find_hi.sv
// Combinational highest-set-bit finder: index of the top set bit plus an any-set flag.
module prio_find_hi #(
  parameter int N = 4
) (
  input  logic [N-1:0]         i_req,
  output logic [$clog2(N)-1:0] o_idx,
  output logic                 o_any
);
  always_comb begin
    o_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (i_req[i]) o_idx = i[$clog2(N)-1:0];
    end
  end

  assign o_any = |i_req;
endmodule

// File: rtl/prio_enc_arb.sv
// Registered N-way priority / round-robin arbiter with a valid/ready output stage.
// Optional grant counter enabled by defining PRIO_ENC_ARB_STATS_EN.
module prio_enc_arb
  import prio_enc_pkg::*;
#(
  parameter int N = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  prio_enc_arb_if.master    bus
`ifdef PRIO_ENC_ARB_STATS_EN
  ,
  output logic [STAT_W-1:0] grant_cnt
`endif
);
  localparam int W = $clog2(N);

  state_t       r_state;
  state_t       w_state_next;
  logic [W-1:0] r_out_idx;
  logic [N-1:0] r_out_onehot;
  logic [N-1:0] r_req_ack;
  logic [W-1:0] r_rr_ptr;

  logic [N-1:0] w_req_masked;
  logic [W-1:0] w_fix_idx, w_msk_idx, w_win_idx, w_rr_ptr_next;
  logic         w_fix_any, w_msk_any, w_load, w_out_valid;
  logic [N-1:0] w_onehot_next;

  // Round-robin window: only requests at or below the pointer compete first.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_mask
      assign w_req_masked[gi] = bus.req[gi] && (W'(gi) <= r_rr_ptr);
    end
  endgenerate

  prio_find_hi #(.N(N)) u_find_all (
    .i_req (bus.req),
    .o_idx (w_fix_idx),
    .o_any (w_fix_any)
  );

  prio_find_hi #(.N(N)) u_find_msk (
    .i_req (w_req_masked),
    .o_idx (w_msk_idx),
    .o_any (w_msk_any)
  );

  assign w_out_valid = (r_state == ST_FULL);
  assign w_load      = (r_state == ST_EMPTY) || (w_out_valid && bus.out_ready);
  assign w_win_idx   = (bus.mode == MODE_RR && w_msk_any) ? w_msk_idx : w_fix_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_EMPTY;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    if (w_load) w_state_next = w_fix_any ? ST_FULL : ST_EMPTY;
  end

  always_comb begin
    w_onehot_next = '0;
    if (w_fix_any) w_onehot_next = N'(1) << w_win_idx;
    w_rr_ptr_next = (w_win_idx == '0) ? W'(N - 1) : w_win_idx - 1'b1;
  end

  // out_idx deliberately keeps its last value when an empty load clears valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_idx    <= '0;
      r_out_onehot <= '0;
      r_req_ack    <= '0;
      r_rr_ptr     <= W'(N - 1);
    end else begin
      r_req_ack <= '0;
      if (w_load) begin
        r_out_onehot <= w_onehot_next;
        r_req_ack    <= w_onehot_next;
        if (w_fix_any) begin
          r_out_idx <= w_win_idx;
          if (bus.mode == MODE_RR) r_rr_ptr <= w_rr_ptr_next;
        end
      end
    end
  end

  assign bus.out_valid  = w_out_valid;
  assign bus.out_idx    = r_out_idx;
  assign bus.out_onehot = r_out_onehot;
  assign bus.req_ack    = r_req_ack;

`ifdef PRIO_ENC_ARB_STATS_EN
  logic [STAT_W-1:0] r_grant_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_grant_cnt <= '0;
    else if (w_out_valid && bus.out_ready && (r_grant_cnt != '1))
      r_grant_cnt <= r_grant_cnt + 1'b1;
  end

  assign grant_cnt = r_grant_cnt;
`endif
endmodule

// File: doc/prio_enc_arb.md
Name: prio_enc_arb

Overview:
- Parametrised, registered successor to the team's 4-to-2 priority encoder.
- Takes N request lines and selects one active line. The selection uses either fixed priority (highest index wins) or round-robin.
- Presents the winning index, plus its one-hot form, through a valid/ready output register.
- Sits between request sources (interrupt lines, channel FIFOs) and a single downstream consumer. A one-hot ack tells the winning source it was taken.

Parameters:
- N, 4, number of request lines; legal N >= 2.
- W, $clog2(N), index width; derived, never overridden.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- req  input  N  request lines; bit i high = source i requesting
- mode  input  1  0 = fixed priority (bit N-1 highest); 1 = round-robin
- req_ack  output  N  one-hot, one-cycle pulse marking the request captured this cycle
- out_valid  output  1  out_idx/out_onehot hold a valid selection
- out_ready  input  1  consumer accepts the selection when out_valid && out_ready
- out_idx  output  W  binary index of the selected request
- out_onehot  output  N  one-hot form of out_idx

Behaviour:
- Reset (async, rst_n low): out_valid=0, out_idx=0, out_onehot=0, req_ack=0, rr_ptr=N-1, FSM=EMPTY. Reset dominates any in-flight selection; the held selection is discarded.
- FSM states:
  - EMPTY: output register free.
  - FULL: selection held.
- Load condition: load = (state==EMPTY) || (out_valid && out_ready).
- On a clock edge with load and |req:
  - register winner k: out_idx=k, out_onehot=1<<k, out_valid=1;
  - req_ack=1<<k for exactly that cycle;
  - state goes to FULL.
- On a clock edge with load and req==0: out_valid=0, out_onehot=0, state goes to EMPTY. out_idx keeps its last value; its value is don't-care while invalid.
- With no load (FULL and !out_ready): all outputs hold and req_ack=0. req changes are ignored.
- Latency:
  - request to out_valid is 1 cycle;
  - back-to-back throughput is 1 selection per cycle while out_ready=1.
- Fixed mode: k = highest set index of req. This is identical to the 4-to-2 truth table for N=4 (req=4'b0110 gives k=2).
- Round-robin mode:
  - search starts at rr_ptr and proceeds downward, wrapping N-1 after 0; k is the first set bit found;
  - after each load with a winner, rr_ptr = (k==0) ? N-1 : k-1.
- rr_ptr update rules:
  - rr_ptr is updated only in round-robin mode;
  - it holds in fixed mode;
  - it holds when no winner is loaded.
- Mode changes take effect at the next load. No selection is altered once registered.
- Boundaries:
  - single request: k is that bit in both modes;
  - all requests set: fixed mode always picks N-1; round-robin cycles N-1, N-2, ..., 0, N-1;
  - request dropped while its selection is held: the held selection is still delivered;
  - simultaneous consume and new request: new selection loads in the same edge, out_valid stays 1.
- Implementations use combinational search plus one output register. No latches; all flops on the async reset.

Optional Feature:
- Macro: PRIO_ENC_ARB_STATS_EN.
- When defined:
  - adds output port grant_cnt [15:0];
  - the counter increments on every out_valid && out_ready and saturates at 16'hFFFF;
  - reset clears it to 0.
- When undefined: port and counter are absent; all other behaviour is identical.

Decomposition:
- Package prio_enc_pkg:
  - mode encoding constants MODE_FIXED=1'b0, MODE_RR=1'b1;
  - state encoding ST_EMPTY/ST_FULL;
  - counter width constant STAT_W=16.
- Sub-module prio_find_hi:
  - purely combinational, parametrised N;
  - returns highest-set index and any-set flag.
- prio_enc_arb builds round-robin from two instances:
  - one on req masked to bits <= rr_ptr;
  - one on the unmasked req;
  - the masked result is used if any bit is set, else the unmasked result.

Test Plan:
- Reset, then idle: rst_n low mid-FULL with out_idx=3 -> out_valid=0, out_onehot=0, rr_ptr=N-1 immediately (async). With req=0 after release -> out_valid stays 0.
- Fixed mode, N=4, out_ready=1, sweep req 4'b0000..4'b1111 -> out_idx matches the 4-to-2 priority table one cycle later. req_ack is one-hot on the winner; out_valid=0 for req=0.
- Round-robin, N=4, req=4'b1111 held, out_ready=1 -> out_idx sequence 3,2,1,0,3 on consecutive cycles; each req_ack is a single pulse.
- Backpressure: req=4'b0100 then out_ready=0 for 5 cycles while req changes to 4'b1000 -> out_idx holds 2 and req_ack stays 0. After out_ready=1 -> the next cycle shows out_idx=3.
- Round-robin wrap with sparse requests: rr_ptr=0 after granting 1, req=4'b0011 -> grants 0. Next cycle, req=4'b0011 -> grants 1 (wrap through 3,2 empty).
- With PRIO_ENC_ARB_STATS_EN: 10 accepted selections -> grant_cnt=10. Force the count to 16'hFFFF and accept again -> stays 16'hFFFF.
